// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, one-hot receiver states and baud helper
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DATA  = 5'b00100,
    STOP  = 5'b01000,
    BREAK = 5'b10000
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop bit synchroniser, resets to the idle-high level
module sync_2ff (
  input  logic sys_clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // two-stage capture of an asynchronous input; both stages reset high so no false edge appears
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with glitch-rejecting start detect and framing check
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int UART_BAUD = 115200
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               uartrx,
  output logic [UART_DW-1:0] odat,
  output logic               uart_rx_done,
  output logic               uart_rx_err,
  output logic               uart_rx_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, UART_BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);

  rx_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         bit_idx;
  logic [UART_DW-1:0] shift_q;
  logic               rx_s2;

  sync_2ff u_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .d       (uartrx),
    .q       (rx_s2)
  );

  // frame FSM: start qualification at half bit, data/stop sampled mid-bit, break holds off restart
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift_q      <= '0;
      odat         <= '0;
      uart_rx_done <= 1'b0;
      uart_rx_err  <= 1'b0;
      uart_rx_busy <= 1'b0;
    end else begin
      uart_rx_done <= 1'b0;
      uart_rx_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s2) begin
            state        <= START;
            cnt          <= '0;
            uart_rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_HALF_LAST) begin
            cnt <= '0;
            if (!rx_s2) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state        <= IDLE;
              uart_rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_BIT_LAST) begin
            cnt              <= '0;
            shift_q[bit_idx] <= rx_s2;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_BIT_LAST) begin
            cnt <= '0;
            if (rx_s2) begin
              odat         <= shift_q;
              uart_rx_done <= 1'b1;
              state        <= IDLE;
              uart_rx_busy <= 1'b0;
            end else begin
              uart_rx_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s2) begin
            state        <= IDLE;
            uart_rx_busy <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          uart_rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: directed corner cases plus randomized frame table
`timescale 1ns/1ps
module tb_uart_rx;

  localparam real BIT_NS = 4340.0;

  logic       sys_clk;
  logic       rst;
  logic       uartrx;
  logic [7:0] odat;
  logic       uart_rx_done;
  logic       uart_rx_err;
  logic       uart_rx_busy;

  uart_rx #(.CLK_FREQ(50_000_000), .UART_BAUD(115200)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .uartrx       (uartrx),
    .odat         (odat),
    .uart_rx_done (uart_rx_done),
    .uart_rx_err  (uart_rx_err),
    .uart_rx_busy (uart_rx_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       is_done;
    logic       both;
    logic       after_pulse;
    logic       busy;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         skew;
    int         gap;
    logic       exp_done;
    logic [7:0] exp_odat;
  } vec_t;

  int   cyc = 0;
  int   busy_cnt = 0;
  logic prev_pulse = 1'b0;
  ev_t  evq[$];
  int   rd_idx = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[8];

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    busy_cnt   <= busy_cnt + ((uart_rx_busy === 1'b1) ? 1 : 0);
    prev_pulse <= (uart_rx_done === 1'b1) || (uart_rx_err === 1'b1);
    if ((uart_rx_done === 1'b1) || (uart_rx_err === 1'b1))
      evq.push_back('{(uart_rx_done === 1'b1),
                      (uart_rx_done === 1'b1) && (uart_rx_err === 1'b1),
                      prev_pulse, (uart_rx_busy === 1'b1), odat, cyc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] d, input real bit_ns, output int t0);
    t0 = cyc + 1;
    uartrx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      uartrx = d[i];
      #(bit_ns);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input real bit_ns, output int t0);
    send_bits(d, bit_ns, t0);
    uartrx = stop;
    #(bit_ns);
    uartrx = 1'b1;
  endtask

  task automatic check_next(input string name, input logic exp_done, input logic [7:0] exp_data,
                            output int ev_cyc);
    ev_t ev;
    ev_cyc = -1;
    chk({name, "_seen"}, 32'(evq.size() > rd_idx), 32'd1);
    if (evq.size() > rd_idx) begin
      ev = evq[rd_idx];
      rd_idx++;
      chk({name, "_kind_done"}, 32'(ev.is_done), 32'(exp_done));
      chk({name, "_odat"}, 32'(ev.data), 32'(exp_data));
      chk({name, "_busy"}, 32'(ev.busy), 32'(!exp_done));
      chk({name, "_done_and_err"}, 32'(ev.both), 32'd0);
      chk({name, "_pulse_len"}, 32'(ev.after_pulse), 32'd0);
      ev_cyc = ev.cyc;
    end
  endtask

  task automatic check_none(input string name);
    chk({name, "_no_pulse"}, 32'(evq.size() - rd_idx), 32'd0);
    rd_idx = evq.size();
  endtask

  initial begin
    int t0, t1, t2, c0, c1, c2, b0;
    logic [7:0] model_last;
    real bit_ns;

    model_last = 8'h12;
    for (int i = 0; i < 8; i++) begin
      if (i < 2) begin
        tbl[i].data = 8'h96;
        tbl[i].stop = 1'b1;
        tbl[i].skew = (i == 0) ? -25 : 25;
      end else begin
        tbl[i].data = 8'($urandom);
        tbl[i].stop = ($urandom_range(0, 3) != 0);
        tbl[i].skew = int'($urandom_range(0, 50)) - 25;
      end
      tbl[i].gap = int'($urandom_range(20, 60));
      tbl[i].exp_done = tbl[i].stop;
      if (tbl[i].stop) model_last = tbl[i].data;
      tbl[i].exp_odat = model_last;
    end

    rst = 1'b1;
    uartrx = 1'b1;
    idle(3);
    chk("reset_odat", 32'(odat), 32'd0);
    chk("reset_done", 32'(uart_rx_done), 32'd0);
    chk("reset_err", 32'(uart_rx_err), 32'd0);
    chk("reset_busy", 32'(uart_rx_busy), 32'd0);
    rst = 1'b0;
    idle(10);

    send_frame(8'hA5, 1'b1, BIT_NS, t0);
    idle(20);
    check_next("single", 1'b1, 8'hA5, c0);
    chk("single_time", 32'(c0), 32'(t0 + 4125));
    chk("single_odat", 32'(odat), 32'hA5);

    send_frame(8'h00, 1'b1, BIT_NS, t0);
    send_frame(8'hFF, 1'b1, BIT_NS, t1);
    send_frame(8'h5A, 1'b1, BIT_NS, t2);
    idle(20);
    check_next("b2b0", 1'b1, 8'h00, c0);
    check_next("b2b1", 1'b1, 8'hFF, c1);
    check_next("b2b2", 1'b1, 8'h5A, c2);
    chk("b2b0_time", 32'(c0), 32'(t0 + 4125));
    chk("b2b_space01", 32'(c1 - c0), 32'd4340);
    chk("b2b_space12", 32'(c2 - c1), 32'd4340);

    b0 = busy_cnt;
    uartrx = 1'b0;
    idle(100);
    uartrx = 1'b1;
    idle(400);
    chk("glitch_busy_cycles", 32'(busy_cnt - b0), 32'd217);
    check_none("glitch");
    chk("glitch_busy_end", 32'(uart_rx_busy), 32'd0);
    chk("glitch_odat", 32'(odat), 32'h5A);

    send_bits(8'h3C, BIT_NS, t0);
    uartrx = 1'b0;
    idle(2000);
    uartrx = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("break_busy_hold", 32'(uart_rx_busy), 32'd1);
    @(negedge sys_clk);
    chk("break_busy_release", 32'(uart_rx_busy), 32'd0);
    check_next("frame_err", 1'b0, 8'h5A, c0);
    chk("frame_err_time", 32'(c0), 32'(t0 + 4125));
    idle(20);
    send_frame(8'h81, 1'b1, BIT_NS, t0);
    idle(20);
    check_next("after_err", 1'b1, 8'h81, c0);

    uartrx = 1'b0;
    idle(434);
    for (int i = 0; i < 3; i++) begin
      uartrx = 1'b1;
      idle(434);
    end
    uartrx = 1'b0;
    idle(200);
    rst = 1'b1;
    uartrx = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst_odat", 32'(odat), 32'd0);
    chk("midrst_busy", 32'(uart_rx_busy), 32'd0);
    idle(500);
    check_none("midrst");
    chk("midrst_odat_hold", 32'(odat), 32'd0);
    send_frame(8'h12, 1'b1, BIT_NS, t0);
    idle(20);
    check_next("after_rst", 1'b1, 8'h12, c0);

    for (int i = 0; i < 8; i++) begin
      bit_ns = BIT_NS * (1000.0 + real'(tbl[i].skew)) / 1000.0;
      send_frame(tbl[i].data, tbl[i].stop, bit_ns, t0);
      idle(tbl[i].gap);
      check_next($sformatf("vec%0d", i), tbl[i].exp_done, tbl[i].exp_odat, c0);
      chk($sformatf("vec%0d_odat_out", i), 32'(odat), 32'(tbl[i].exp_odat));
    end

    idle(50);
    check_none("trailing");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
